// File: rtl/dm_bank_pp.sv
// dm_bank_pp: parametrised single-port data memory with byte strobes and a clear sweep after reset.
// Define DM_FWD_EN to return the merged word on a same-cycle read+write; otherwise the read sees old data.
module dm_bank_pp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   dataw,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                read,
  input  logic                write,
  output logic [DATA_W-1:0]   data,
  output logic                rvalid,
  output logic                busy,
  output logic                err
);

  localparam int NB = DATA_W / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEP  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_nx;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic              in_range;
  logic              acc_rd;
  logic              acc_wr;
  logic              oor;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     cidx;
  logic [DATA_W-1:0] old_w;
  logic [DATA_W-1:0] mrg_w;
  logic [DATA_W-1:0] rd_w;

  assign ready    = (state == READY);
  assign in_range = ({1'b0, addr} < DEP);
  assign idx      = addr[IW-1:0];
  assign cidx     = clr_cnt[IW-1:0];

  assign acc_rd = ready & read;
  assign acc_wr = ready & write & in_range;
  assign oor    = ready & (read | write) & ~in_range;

  assign old_w = mem[idx];

  always_comb begin
    mrg_w = old_w;
    for (int i = 0; i < NB; i++) begin
      if (wstrb[i]) mrg_w[8*i +: 8] = dataw[8*i +: 8];
    end
  end

`ifdef DM_FWD_EN
  assign rd_w = write ? mrg_w : old_w;
`else
  assign rd_w = old_w;
`endif

  // sweep controller
  always_comb begin
    state_nx = state;
    clr_nx   = clr_cnt;
    unique case (state)
      CLEAR: begin
        clr_nx = clr_cnt + 1'b1;
        if (clr_cnt == LAST) begin
          state_nx = READY;
          clr_nx   = '0;
        end
      end
      READY: begin
        state_nx = READY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_nx;
      busy    <= (state_nx == CLEAR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data   <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= acc_rd;
      err    <= oor;
      if (acc_rd) data <= in_range ? rd_w : '0;
    end
  end

  // storage has no reset; the sweep zeroes it instead
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cidx] <= '0;
      end else if (acc_wr) begin
        mem[idx] <= mrg_w;
      end
    end
  end

endmodule

// File: tb/tb_dm_bank_pp.sv
// tb_dm_bank_pp: scoreboard bench for dm_bank_pp.
// Two instances: DEPTH=256 (sel 0) and DEPTH=200 (sel 1).
module tb_dm_bank_pp;

`ifdef DM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;

  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_dataw, b_dataw;
  logic [1:0]  a_wstrb, b_wstrb;
  logic        a_read, b_read;
  logic        a_write, b_write;
  logic [15:0] a_data, b_data;
  logic        a_rvalid, b_rvalid;
  logic        a_busy, b_busy;
  logic        a_err, b_err;

  dm_bank_pp #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .addr(a_addr), .dataw(a_dataw),
    .wstrb(a_wstrb), .read(a_read), .write(a_write),
    .data(a_data), .rvalid(a_rvalid), .busy(a_busy), .err(a_err)
  );

  dm_bank_pp #(.DATA_W(16), .ADDR_W(8), .DEPTH(200)) dut_b (
    .clk(clk), .rst(rst), .addr(b_addr), .dataw(b_dataw),
    .wstrb(b_wstrb), .read(b_read), .write(b_write),
    .data(b_data), .rvalid(b_rvalid), .busy(b_busy), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        sel;
    logic [15:0] data;
    logic        rv;
    logic        er;
    logic        bz;
  } obs_t;

  obs_t q_exp[$];
  obs_t q_obs[$];

  logic [15:0] mema [256];
  logic [15:0] memb [200];
  int          rema, remb;
  logic [15:0] holda, holdb;

  int tests = 0;
  int fails = 0;

  task automatic clr_inputs();
    a_addr = '0; a_dataw = '0; a_wstrb = '0; a_read = 0; a_write = 0;
    b_addr = '0; b_dataw = '0; b_wstrb = '0; b_read = 0; b_write = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rema = 256;
    remb = 200;
    holda = '0;
    holdb = '0;
    for (int i = 0; i < 256; i++) mema[i] = '0;
    for (int i = 0; i < 200; i++) memb[i] = '0;
  endtask

  task automatic wait_sweep(output int na, output int nb);
    int g;
    na = 0;
    nb = 0;
    g = 0;
    while ((a_busy || b_busy) && g < 2000) begin
      na += int'(a_busy);
      nb += int'(b_busy);
      @(posedge clk);
      #1;
      g++;
    end
    rema = 0;
    remb = 0;
  endtask

  // one request cycle; model result goes to q_exp, DUT result to q_obs
  task automatic op(input bit sel, input bit rd, input bit wr,
                    input logic [7:0] ad, input logic [15:0] dw,
                    input logic [1:0] st);
    obs_t e, o;
    int rem, dep;
    logic [15:0] hold, old, mrg;
    bit inr;
    dep  = sel ? 200 : 256;
    rem  = sel ? remb : rema;
    hold = sel ? holdb : holda;
    e.sel = sel; e.rv = 0; e.er = 0; e.bz = 0;
    if (rem > 0) begin
      rem--;
      e.bz = (rem > 0);
    end else begin
      inr = int'(ad) < dep;
      old = '0;
      if (inr) old = sel ? memb[ad] : mema[ad];
      mrg = old;
      for (int b = 0; b < 2; b++)
        if (st[b]) mrg[8*b +: 8] = dw[8*b +: 8];
      e.rv = rd;
      e.er = (rd || wr) && !inr;
      if (rd) hold = !inr ? 16'h0 : ((FWD && wr) ? mrg : old);
      if (wr && inr) begin
        if (sel) memb[ad] = mrg;
        else mema[ad] = mrg;
      end
    end
    e.data = hold;
    if (sel) begin remb = rem; holdb = hold; end
    else begin rema = rem; holda = hold; end
    clr_inputs();
    if (sel) begin
      b_addr = ad; b_dataw = dw; b_wstrb = st; b_read = rd; b_write = wr;
    end else begin
      a_addr = ad; a_dataw = dw; a_wstrb = st; a_read = rd; a_write = wr;
    end
    @(posedge clk);
    #1;
    o.sel  = sel;
    o.data = sel ? b_data : a_data;
    o.rv   = sel ? b_rvalid : a_rvalid;
    o.er   = sel ? b_err : a_err;
    o.bz   = sel ? b_busy : a_busy;
    q_exp.push_back(e);
    q_obs.push_back(o);
    clr_inputs();
  endtask

  task automatic test_reset();
    int na, nb;
    do_reset();
    tests++;
    if ({a_busy, a_rvalid, a_err, a_data} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      fails++;
      $display("FAIL reset_a got busy=%b rv=%b err=%b data=%h want 1 0 0 0000",
               a_busy, a_rvalid, a_err, a_data);
    end
    tests++;
    if ({b_busy, b_rvalid, b_err, b_data} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      fails++;
      $display("FAIL reset_b got busy=%b rv=%b err=%b data=%h want 1 0 0 0000",
               b_busy, b_rvalid, b_err, b_data);
    end
    wait_sweep(na, nb);
    tests++;
    if (na != 256) begin
      fails++;
      $display("FAIL busy_len_a got %0d want 256", na);
    end
    tests++;
    if (nb != 200) begin
      fails++;
      $display("FAIL busy_len_b got %0d want 200", nb);
    end
  endtask

  task automatic test_cleared();
    obs_t e, o;
    int n = 0;
    op(0, 1, 0, 8'h00, 16'h0, 2'b00);
    op(0, 1, 0, 8'hFF, 16'h0, 2'b00);
    op(1, 1, 0, 8'd0, 16'h0, 2'b00);
    op(1, 1, 0, 8'd199, 16'h0, 2'b00);
    while (q_exp.size() != 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL cleared[%0d] sel=%0d got d=%h rv=%b err=%b busy=%b want d=%h rv=%b err=%b busy=%b",
                 n, o.sel, o.data, o.rv, o.er, o.bz, e.data, e.rv, e.er, e.bz);
      end
      n++;
    end
  endtask

  task automatic test_strobe();
    obs_t e, o;
    int n = 0;
    op(0, 0, 1, 8'd4, 16'h001A, 2'b11);
    op(0, 1, 0, 8'd4, 16'h0, 2'b00);
    op(0, 0, 1, 8'd4, 16'hFF00, 2'b10);
    op(0, 1, 0, 8'd4, 16'h0, 2'b00);
    op(0, 0, 1, 8'd4, 16'h5555, 2'b00);
    op(0, 1, 0, 8'd4, 16'h0, 2'b00);
    op(0, 0, 1, 8'd4, 16'h77C3, 2'b01);
    op(0, 0, 0, 8'd4, 16'h0, 2'b00);
    op(0, 1, 0, 8'd4, 16'h0, 2'b00);
    while (q_exp.size() != 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL strobe[%0d] sel=%0d got d=%h rv=%b err=%b busy=%b want d=%h rv=%b err=%b busy=%b",
                 n, o.sel, o.data, o.rv, o.er, o.bz, e.data, e.rv, e.er, e.bz);
      end
      n++;
    end
  endtask

  task automatic test_rw_same();
    obs_t e, o;
    int n = 0;
    op(0, 0, 1, 8'd7, 16'h0008, 2'b11);
    op(0, 1, 1, 8'd7, 16'h1234, 2'b01);
    op(0, 1, 0, 8'd7, 16'h0, 2'b00);
    op(0, 1, 1, 8'd7, 16'hAB00, 2'b10);
    op(0, 1, 0, 8'd7, 16'h0, 2'b00);
    while (q_exp.size() != 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL rw_same[%0d] sel=%0d got d=%h rv=%b err=%b busy=%b want d=%h rv=%b err=%b busy=%b",
                 n, o.sel, o.data, o.rv, o.er, o.bz, e.data, e.rv, e.er, e.bz);
      end
      n++;
    end
  endtask

  task automatic test_range();
    obs_t e, o;
    int n = 0;
    logic [7:0] chk [5];
    chk[0] = 8'd0; chk[1] = 8'd50; chk[2] = 8'd122;
    chk[3] = 8'd199; chk[4] = 8'd186;
    for (int i = 0; i < 5; i++)
      op(1, 0, 1, chk[i], 16'h1100 + 16'(i), 2'b11);
    op(1, 1, 0, 8'd200, 16'h0, 2'b00);
    op(1, 0, 1, 8'd250, 16'hBEEF, 2'b11);
    op(1, 1, 1, 8'd255, 16'hBEEF, 2'b11);
    op(1, 0, 0, 8'd0, 16'h0, 2'b00);
    for (int i = 0; i < 5; i++)
      op(1, 1, 0, chk[i], 16'h0, 2'b00);
    while (q_exp.size() != 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL range[%0d] sel=%0d got d=%h rv=%b err=%b busy=%b want d=%h rv=%b err=%b busy=%b",
                 n, o.sel, o.data, o.rv, o.er, o.bz, e.data, e.rv, e.er, e.bz);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    int n = 0;
    logic [7:0] ad;
    for (int i = 0; i < 16; i++)
      op(0, 0, 1, 8'(32 + i), 16'($urandom), 2'($urandom_range(0, 3)));
    for (int i = 0; i < 16; i++)
      op(0, 1, 0, 8'(32 + i), 16'h0, 2'b00);
    for (int i = 0; i < 12; i++) begin
      ad = 8'($urandom_range(0, 255));
      op(0, 0, 1, ad, 16'($urandom), 2'b11);
      op(0, 1, 0, ad, 16'h0, 2'b00);
    end
    while (q_exp.size() != 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL b2b[%0d] sel=%0d got d=%h rv=%b err=%b busy=%b want d=%h rv=%b err=%b busy=%b",
                 n, o.sel, o.data, o.rv, o.er, o.bz, e.data, e.rv, e.er, e.bz);
      end
      n++;
    end
  endtask

  task automatic test_mid_reset();
    obs_t e, o;
    int n = 0;
    int na, nb;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      if (i < 50) op(0, 0, 0, 8'd0, 16'h0, 2'b00);
      else if (i % 2 == 0) op(0, 0, 1, 8'd5, 16'hBEEF, 2'b11);
      else op(0, 1, 1, 8'd5, 16'hC0DE, 2'b11);
    end
    do_reset();
    tests++;
    if (a_busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_busy got %b want 1", a_busy);
    end
    wait_sweep(na, nb);
    tests++;
    if (na != 256) begin
      fails++;
      $display("FAIL mid_reset_len got %0d want 256", na);
    end
    op(0, 1, 0, 8'd5, 16'h0, 2'b00);
    op(0, 1, 0, 8'd99, 16'h0, 2'b00);
    while (q_exp.size() != 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL mid_reset[%0d] sel=%0d got d=%h rv=%b err=%b busy=%b want d=%h rv=%b err=%b busy=%b",
                 n, o.sel, o.data, o.rv, o.er, o.bz, e.data, e.rv, e.er, e.bz);
      end
      n++;
    end
  endtask

  task automatic test_ready_reset();
    obs_t e, o;
    int n = 0;
    int na, nb;
    op(0, 0, 1, 8'd1, 16'h0009, 2'b11);
    op(0, 1, 0, 8'd1, 16'h0, 2'b00);
    do_reset();
    wait_sweep(na, nb);
    tests++;
    if (na != 256) begin
      fails++;
      $display("FAIL ready_reset_len got %0d want 256", na);
    end
    op(0, 1, 0, 8'd1, 16'h0, 2'b00);
    while (q_exp.size() != 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL ready_reset[%0d] sel=%0d got d=%h rv=%b err=%b busy=%b want d=%h rv=%b err=%b busy=%b",
                 n, o.sel, o.data, o.rv, o.er, o.bz, e.data, e.rv, e.er, e.bz);
      end
      n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_cleared();
    test_strobe();
    test_rw_same();
    test_range();
    test_back_to_back();
    test_mid_reset();
    test_ready_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
